// File: rtl/dem_switching_block_ns.sv
// Noise-shaped DEM switching layer: each lane splits code x into (x+s)/2 and (x-s)/2,
// with s chosen by a per-lane shaping accumulator, a shared PN bit, or a fixed rule.
module dem_switching_block_ns #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned LANES     = 1,
  parameter int unsigned ACC_W     = 4,
  parameter logic [14:0] LFSR_SEED = 15'h0001
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       valid_i,
  input  logic [1:0]                 mode_i,
  input  logic [LANES*WIDTH-1:0]     x_in_i,
  output logic                       valid_o,
  output logic [LANES*(WIDTH-1)-1:0] x_out1_o,
  output logic [LANES*(WIDTH-1)-1:0] x_out2_o,
  output logic [LANES*2-1:0]         s_out_o,
  output logic [LANES-1:0]           range_err_o
);
  localparam logic [WIDTH-1:0] X_MAX       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       S_ZERO      = 2'b00;
  localparam logic [1:0]       S_POS       = 2'b01;
  localparam logic [1:0]       S_NEG       = 2'b11;
  localparam logic [1:0]       MODE_RANDOM = 2'd0;
  localparam logic [1:0]       MODE_FIXED  = 2'd2;

  logic [14:0]                 lfsr_q;
  logic [ACC_W-1:0]            acc_q [LANES];
  logic [ACC_W-1:0]            acc_d [LANES];
  logic [WIDTH-1:0]            x_clip [LANES];
  logic [1:0]                  s_d [LANES];
  logic                        valid_q;
  logic [LANES*(WIDTH-1)-1:0]  x_out1_q, x_out1_d;
  logic [LANES*(WIDTH-1)-1:0]  x_out2_q, x_out2_d;
  logic [LANES*2-1:0]          s_out_q, s_out_d;
  logic [LANES-1:0]            err_q, err_d;

  // Per-lane clip, switching decision, saturating accumulator update and split.
  always_comb begin
    x_out1_d = '0;
    x_out2_d = '0;
    s_out_d  = '0;
    err_d    = '0;
    for (int l = 0; l < LANES; l++) begin
      if (x_in_i[l*WIDTH +: WIDTH] > X_MAX) begin
        x_clip[l] = X_MAX;
        err_d[l]  = 1'b1;
      end else begin
        x_clip[l] = x_in_i[l*WIDTH +: WIDTH];
        err_d[l]  = 1'b0;
      end

      if (x_clip[l][0]) begin
        case (mode_i)
          MODE_RANDOM: s_d[l] = lfsr_q[l] ? S_POS : S_NEG;
          MODE_FIXED:  s_d[l] = S_POS;
          default: begin
            // Steer the accumulator back toward zero; PN breaks the tie at zero.
            if (acc_q[l][ACC_W-1]) begin
              s_d[l] = S_POS;
            end else if (acc_q[l] != '0) begin
              s_d[l] = S_NEG;
            end else begin
              s_d[l] = lfsr_q[l] ? S_POS : S_NEG;
            end
          end
        endcase
      end else begin
        s_d[l] = S_ZERO;
      end

      if ((s_d[l] == S_POS) && (acc_q[l] != ACC_MAX)) begin
        acc_d[l] = acc_q[l] + ACC_ONE;
      end else if ((s_d[l] == S_NEG) && (acc_q[l] != ACC_MIN)) begin
        acc_d[l] = acc_q[l] - ACC_ONE;
      end else begin
        acc_d[l] = acc_q[l];
      end

      // x+s and x-s are even and non-negative, so the halves are exact.
      x_out1_d[l*(WIDTH-1) +: (WIDTH-1)] =
        (WIDTH-1)'(({1'b0, x_clip[l]} + {{(WIDTH-1){s_d[l][1]}}, s_d[l]}) >> 1);
      x_out2_d[l*(WIDTH-1) +: (WIDTH-1)] =
        (WIDTH-1)'(({1'b0, x_clip[l]} - {{(WIDTH-1){s_d[l][1]}}, s_d[l]}) >> 1);
      s_out_d[2*l +: 2] = s_d[l];
    end
  end

  // Output stage, accumulators and LFSR; a clear drops the sample and holds data outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q   <= LFSR_SEED;
      valid_q  <= 1'b0;
      x_out1_q <= '0;
      x_out2_q <= '0;
      s_out_q  <= '0;
      err_q    <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (clear_i) begin
      lfsr_q  <= LFSR_SEED;
      valid_q <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else if (valid_i) begin
      lfsr_q   <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
      valid_q  <= 1'b1;
      x_out1_q <= x_out1_d;
      x_out2_q <= x_out2_d;
      s_out_q  <= s_out_d;
      err_q    <= err_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign x_out1_o    = x_out1_q;
  assign x_out2_o    = x_out2_q;
  assign s_out_o     = s_out_q;
  assign range_err_o = err_q;
endmodule

// File: tb/tb_dem_switching_block_ns.sv
// Directed and randomized bench for dem_switching_block_ns with four lanes,
// hand-computed vectors plus a small behavioral reference for long streams.
module tb_dem_switching_block_ns;
  localparam int W  = 5;
  localparam int L  = 4;
  localparam int AW = 4;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 clear_i;
  logic                 valid_i;
  logic [1:0]           mode_i;
  logic [L*W-1:0]       x_in_i;
  logic                 valid_o;
  logic [L*(W-1)-1:0]   x_out1_o;
  logic [L*(W-1)-1:0]   x_out2_o;
  logic [L*2-1:0]       s_out_o;
  logic [L-1:0]         range_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] m_lfsr;
  int m_acc [L];
  int e_s [L];
  int e_o1 [L];
  int e_o2 [L];
  int e_err [L];
  int e_x [L];
  int win [L];

  always #5 clk_i = ~clk_i;

  dem_switching_block_ns #(
    .WIDTH(W), .LANES(L), .ACC_W(AW), .LFSR_SEED(15'h0001)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .valid_i(valid_i),
    .mode_i(mode_i), .x_in_i(x_in_i), .valid_o(valid_o), .x_out1_o(x_out1_o),
    .x_out2_o(x_out2_o), .s_out_o(s_out_o), .range_err_o(range_err_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int s_of(input int l);
    return int'($signed(s_out_o[2*l +: 2]));
  endfunction
  function automatic int o1_of(input int l);
    return int'(x_out1_o[l*(W-1) +: (W-1)]);
  endfunction
  function automatic int o2_of(input int l);
    return int'(x_out2_o[l*(W-1) +: (W-1)]);
  endfunction
  function automatic logic [L*W-1:0] pack(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic model_reset();
    m_lfsr = 15'h0001;
    for (int l = 0; l < L; l++) m_acc[l] = 0;
  endtask

  // Reference: PN for lane l is lfsr[l] before the advance; accumulator clamps at +/-7.
  task automatic model_step(input logic [1:0] m, input logic [L*W-1:0] xv);
    for (int l = 0; l < L; l++) begin
      int x;
      int s;
      logic pn;
      x = int'(xv[l*W +: W]);
      e_err[l] = (x > 16) ? 1 : 0;
      if (x > 16) x = 16;
      e_x[l] = x;
      pn = m_lfsr[l];
      s = 0;
      if ((x % 2) == 1) begin
        if (m == 2'd0)       s = pn ? 1 : -1;
        else if (m == 2'd2)  s = 1;
        else if (m_acc[l] > 0) s = -1;
        else if (m_acc[l] < 0) s = 1;
        else                 s = pn ? 1 : -1;
      end
      e_s[l]  = s;
      e_o1[l] = (x + s) / 2;
      e_o2[l] = (x - s) / 2;
      m_acc[l] = m_acc[l] + s;
      if (m_acc[l] > 7)  m_acc[l] = 7;
      if (m_acc[l] < -7) m_acc[l] = -7;
    end
    m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
  endtask

  task automatic sample(input logic [1:0] m, input logic [L*W-1:0] xv);
    model_step(m, xv);
    clear_i = 1'b0;
    valid_i = 1'b1;
    mode_i  = m;
    x_in_i  = xv;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("valid_o", int'(valid_o), 1);
    for (int l = 0; l < L; l++) begin
      chk($sformatf("s[%0d]", l), s_of(l), e_s[l]);
      chk($sformatf("out1[%0d]", l), o1_of(l), e_o1[l]);
      chk($sformatf("out2[%0d]", l), o2_of(l), e_o2[l]);
      chk($sformatf("err[%0d]", l), int'(range_err_o[l]), e_err[l]);
      chk($sformatf("sum[%0d]", l), o1_of(l) + o2_of(l), e_x[l]);
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_out1"}, int'(x_out1_o), 0);
    chk({tag, "_out2"}, int'(x_out2_o), 0);
    chk({tag, "_s"}, int'(s_out_o), 0);
    chk({tag, "_err"}, int'(range_err_o), 0);
  endtask

  initial begin
    int exp_s_a [3];
    int exp_o1_a [3];
    reset_i = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    mode_i  = 2'd0;
    x_in_i  = '0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check_zero("rst_rel");

    // First PN bit is 1, third is 0: shaped s = +1, -1, -1.
    exp_s_a  = '{1, -1, -1};
    exp_o1_a = '{3, 2, 2};
    for (int i = 0; i < 3; i++) begin
      sample(2'd1, pack(5, 0, 0, 0));
      chk("a_s", s_of(0), exp_s_a[i]);
      chk("a_o1", o1_of(0), exp_o1_a[i]);
      chk("a_o2", o2_of(0), 5 - exp_o1_a[i]);
    end

    // Idle cycles hold data outputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      chk("hold_valid", int'(valid_o), 0);
      chk("hold_s", s_of(0), -1);
      chk("hold_o1", o1_of(0), 2);
      chk("hold_o2", o2_of(0), 3);
    end
    // Accumulator held at -1, so shaped s must be +1.
    sample(2'd1, pack(5, 0, 0, 0));
    chk("hold_acc_s", s_of(0), 1);

    // Clear beats valid: sample dropped, outputs hold.
    clear_i = 1'b1;
    valid_i = 1'b1;
    mode_i  = 2'd1;
    x_in_i  = pack(9, 9, 9, 9);
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    model_reset();
    chk("clr_valid", int'(valid_o), 0);
    chk("clr_hold_s", s_of(0), 1);
    chk("clr_hold_o1", o1_of(0), 3);
    sample(2'd0, pack(5, 0, 0, 0));
    chk("clr_seed_s", s_of(0), 1);

    // Fixed mode drives acc to +7; shaped mode then needs seven -1 steps.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      sample(2'd2, pack(3, 3, 3, 3));
      chk("sat_s", s_of(0), 1);
      chk("sat_o1", o1_of(0), 2);
      chk("sat_o2", o2_of(0), 1);
    end
    for (int i = 0; i < 7; i++) begin
      sample(2'd1, pack(3, 3, 3, 3));
      chk("desat_s", s_of(0), -1);
      chk("desat_o1", o1_of(0), 1);
    end

    // Range clipping, per-lane error flags and code bounds.
    sample(2'd0, pack(20, 17, 31, 16));
    chk("rng_err", int'(range_err_o), 7);
    for (int l = 0; l < L; l++) begin
      chk("rng_o1", o1_of(l), 8);
      chk("rng_o2", o2_of(l), 8);
      chk("rng_s", s_of(l), 0);
    end
    sample(2'd0, pack(16, 2, 2, 2));
    chk("b16_err", int'(range_err_o[0]), 0);
    chk("b16_o1", o1_of(0), 8);
    sample(2'd0, pack(0, 2, 2, 2));
    chk("b0_o1", o1_of(0), 0);
    chk("b0_o2", o2_of(0), 0);
    sample(2'd0, pack(1, 2, 2, 2));
    chk("b1_sum", o1_of(0) + o2_of(0), 1);

    // Asynchronous reset between edges during a random-mode stream.
    for (int i = 0; i < 5; i++) begin
      sample(2'd0, pack(2*$urandom_range(0, 7) + 1, 2*$urandom_range(0, 7) + 1,
                        2*$urandom_range(0, 7) + 1, 2*$urandom_range(0, 7) + 1));
    end
    #2;
    reset_i = 1'b1;
    #1;
    check_zero("arst");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_reset();
    sample(2'd0, pack(7, 7, 7, 7));
    chk("arst_s0", s_of(0), 1);
    chk("arst_s1", s_of(1), -1);
    chk("arst_o1_0", o1_of(0), 4);
    chk("arst_o1_1", o1_of(1), 3);
    for (int i = 0; i < 8; i++) begin
      sample(2'd0, pack(2*$urandom_range(0, 7) + 1, 2*$urandom_range(0, 7) + 1,
                        2*$urandom_range(0, 7) + 1, 2*$urandom_range(0, 7) + 1));
    end

    // Long random stream, all modes and legal codes.
    for (int i = 0; i < 10000; i++) begin
      sample(2'($urandom_range(0, 3)),
             pack($urandom_range(0, 16), $urandom_range(0, 16),
                  $urandom_range(0, 16), $urandom_range(0, 16)));
    end

    // Shaped-only run from a cleared state keeps the running sum within +/-1.
    do_clear();
    for (int l = 0; l < L; l++) win[l] = 0;
    for (int i = 0; i < 300; i++) begin
      sample(2'd1, pack($urandom_range(0, 16), $urandom_range(0, 16),
                        $urandom_range(0, 16), $urandom_range(0, 16)));
      for (int l = 0; l < L; l++) begin
        win[l] = win[l] + s_of(l);
        chk("win_bound", int'(win[l] <= 1 && win[l] >= -1), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
